// File: rtl/fir_pkg.sv
// Shared types for the FIR sample transmitter: default sample width,
// sample type and serializer state encoding.
package fir_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous sample FIFO with first-word fall-through read data.
// Push is ignored when full and pop is ignored when empty.
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    // Full is taken from the registered count, so a pop in the same cycle
    // never frees room for a push until the following cycle.
    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fir_sample_tx.sv
// Buffers signed samples and shifts them out MSB first, one bit per bit_en
// strobe, with a frame_sync marker on each MSB and an underrun pulse on drain.
//
//   state | meaning
//   IDLE  | no frame active, ser_out parked at IDLE_BIT
//   SHIFT | frame in progress, bit_cnt_q bits still to follow the current one
module fir_sample_tx
    import fir_pkg::*;
#(
    parameter int   DATA_W     = DATA_W_DEFAULT,
    parameter int   FIFO_DEPTH = 4,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     bit_en,
    output logic                     ser_out,
    output logic                     frame_sync,
    output logic                     busy,
    output logic                     underrun
);

    localparam int CNT_W = $clog2(DATA_W);

    tx_state_t                  state_q, state_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]          shreg_q, shreg_d;
    logic                       ser_q, ser_d;
    logic                       fs_q, fs_d;
    logic                       und_q, und_d;

    logic                       fifo_push, fifo_pop;
    logic [DATA_W-1:0]          fifo_rd_data;
    logic                       fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       load;

    assign fifo_push = s_valid && !fifo_full;
    assign s_ready   = !fifo_full;

    fir_sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (s_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // A frame (re)starts from IDLE or at the end of the last bit, on a strobe.
    always_comb begin
        load = 1'b0;
        if (bit_en && !fifo_empty) begin
            load = (state_q == IDLE) || (bit_cnt_q == '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ser_d     = ser_q;
        fs_d      = fs_q;
        und_d     = 1'b0;
        fifo_pop  = 1'b0;

        if (bit_en) begin
            if (load) begin
                fifo_pop  = 1'b1;
                shreg_d   = {fifo_rd_data[DATA_W-2:0], 1'b0};
                ser_d     = fifo_rd_data[DATA_W-1];
                fs_d      = 1'b1;
                bit_cnt_d = CNT_W'(DATA_W - 1);
                state_d   = SHIFT;
            end else begin
                case (state_q)
                    IDLE: begin
                        ser_d = IDLE_BIT;
                        fs_d  = 1'b0;
                    end
                    SHIFT: begin
                        if (bit_cnt_q != '0) begin
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                            ser_d     = shreg_q[DATA_W-1];
                            fs_d      = 1'b0;
                            bit_cnt_d = bit_cnt_q - 1'b1;
                        end else begin
                            state_d = IDLE;
                            ser_d   = IDLE_BIT;
                            fs_d    = 1'b0;
                            und_d   = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        ser_d   = IDLE_BIT;
                        fs_d    = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ser_q     <= IDLE_BIT;
            fs_q      <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ser_q     <= ser_d;
            fs_q      <= fs_d;
            und_q     <= und_d;
        end
    end

    assign ser_out    = ser_q;
    assign frame_sync = fs_q;
    assign underrun   = und_q;
    assign busy       = (state_q == SHIFT) || (fifo_count != '0);

endmodule

// File: tb/tb_fir_sample_tx.sv
// Directed bench for fir_sample_tx: framing, back-to-back frames, FIFO
// back-pressure, reset abort and same-cycle push/strobe behaviour.
module tb_fir_sample_tx;

    localparam int DW = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          bit_en  = 1'b0;
    logic          s_ready, ser_out, frame_sync, busy, underrun;

    int n_cmp = 0;
    int n_err = 0;

    fir_sample_tx #(
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .IDLE_BIT   (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .bit_en     (bit_en),
        .ser_out    (ser_out),
        .frame_sync (frame_sync),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        check("push_ready", 32'(s_ready), 32'd1);
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [DW-1:0] pat;
        logic [31:0]   exp32;
        logic [79:0]   rx;
        logic [DW-1:0] dv [5];

        // reset state
        #2;
        check("rst_ser", 32'(ser_out), 32'd0);
        check("rst_fs", 32'(frame_sync), 32'd0);
        check("rst_und", 32'(underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single frame, bit_en every third clock
        pat = 16'hA5C3;
        push(pat);
        check("t1_busy_queued", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
            tick();
            check("t1_hold", 32'(ser_out), (i == 0) ? 32'd0 : 32'(pat[16-i]));
            bit_en = 1'b1;
            tick();
            bit_en = 1'b0;
            check("t1_bit", 32'(ser_out), 32'(pat[15-i]));
            check("t1_fs", 32'(frame_sync), 32'(i == 0));
            check("t1_und_mid", 32'(underrun), 32'd0);
        end
        tick();
        tick();
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        check("t1_und_pulse", 32'(underrun), 32'd1);
        check("t1_ser_idle", 32'(ser_out), 32'd0);
        check("t1_fs_idle", 32'(frame_sync), 32'd0);
        check("t1_busy_done", 32'(busy), 32'd0);
        tick();
        check("t1_und_clear", 32'(underrun), 32'd0);

        // two back-to-back frames, bit_en every clock
        push(16'h8001);
        push(16'h7FFE);
        exp32 = 32'h8001_7FFE;
        bit_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("t2_bit", 32'(ser_out), 32'(exp32[31-i]));
            check("t2_fs", 32'(frame_sync), 32'((i == 0) || (i == 16)));
            check("t2_und_mid", 32'(underrun), 32'd0);
        end
        tick();
        check("t2_und_pulse", 32'(underrun), 32'd1);
        check("t2_ser_idle", 32'(ser_out), 32'd0);
        bit_en = 1'b0;
        tick();
        check("t2_und_clear", 32'(underrun), 32'd0);
        check("t2_busy_done", 32'(busy), 32'd0);

        // fill FIFO with strobes off, then pop against a held push
        dv[0] = 16'hDEAD;
        dv[1] = 16'hBEEF;
        dv[2] = 16'h0F0F;
        dv[3] = 16'hF00F;
        dv[4] = 16'h1357;
        for (int j = 0; j < 4; j++) begin
            push(dv[j]);
        end
        check("t3_full_ready", 32'(s_ready), 32'd0);
        s_data  = dv[4];
        s_valid = 1'b1;
        tick();
        tick();
        check("t3_held_ready", 32'(s_ready), 32'd0);
        check("t3_held_ser", 32'(ser_out), 32'd0);
        check("t3_held_busy", 32'(busy), 32'd1);
        bit_en = 1'b1;
        tick();
        check("t3_pop_no_push", 32'(s_ready), 32'd1);
        rx = '0;
        rx[79] = ser_out;
        check("t3_fs", 32'(frame_sync), 32'd1);
        tick();
        s_valid = 1'b0;
        check("t3_push_next", 32'(s_ready), 32'd0);
        rx[78] = ser_out;
        check("t3_fs", 32'(frame_sync), 32'd0);
        for (int k = 2; k < 80; k++) begin
            tick();
            rx[79-k] = ser_out;
            check("t3_fs", 32'(frame_sync), 32'((k % 16) == 0));
        end
        tick();
        check("t3_und_pulse", 32'(underrun), 32'd1);
        bit_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("t3_sample", 32'(rx[79-16*j -: 16]), 32'(dv[j]));
        end
        tick();

        // reset in the middle of 0x1234 with two samples queued
        pat = 16'h1234;
        push(pat);
        push(16'h5678);
        push(16'h9ABC);
        bit_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_bit", 32'(ser_out), 32'(pat[15-i]));
        end
        rst_n = 1'b0;
        #1;
        check("t4_rst_ser", 32'(ser_out), 32'd0);
        check("t4_rst_fs", 32'(frame_sync), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_ready", 32'(s_ready), 32'd1);
        bit_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bit_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4_quiet_ser", 32'(ser_out), 32'd0);
            check("t4_quiet_busy", 32'(busy), 32'd0);
        end

        // push on the same cycle as a strobe into an empty FIFO
        s_data  = 16'h8000;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("t5_no_same_fs", 32'(frame_sync), 32'd0);
        check("t5_no_same_ser", 32'(ser_out), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        tick();
        check("t5_next_fs", 32'(frame_sync), 32'd1);
        check("t5_next_ser", 32'(ser_out), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("t5_last_ser", 32'(ser_out), 32'd0);
        tick();
        check("t5_und_pulse", 32'(underrun), 32'd1);
        check("t5_busy_done", 32'(busy), 32'd0);
        bit_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_sample_tx.md
FIR_SAMPLE_TX -- requirements
Module: fir_sample_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning buffered samples (power of two, >=2).
REQ-003 SHALL have parameter IDLE_BIT, default 1'b0, meaning ser_out level when no frame is active.
REQ-004 SHALL have port clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_data  input  DATA_W  signed sample to transmit.
REQ-007 SHALL have port s_valid  input  1  s_data valid.
REQ-008 SHALL have port s_ready  output  1  block can accept a sample this cycle.
REQ-009 SHALL have port bit_en  input  1  one-cycle bit-rate strobe; serial outputs advance only on cycles with bit_en=1.
REQ-010 SHALL have port ser_out  output  1  serial sample bit, MSB first (drives a FIR in_sample input).
REQ-011 SHALL have port frame_sync  output  1  high during the MSB bit period of each frame.
REQ-012 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse when a frame ends and the FIFO is empty.

Function
REQ-014 SHALL accept a sample on any cycle with s_valid=1 and s_ready=1 and write it to the FIFO.
REQ-015 SHALL drive s_ready = not FIFO full; push with full FIFO SHALL NOT occur even if a pop happens in the same cycle.
REQ-016 SHALL preserve sample order; no sample is dropped or duplicated.
REQ-017 SHALL implement FSM states IDLE and SHIFT.
REQ-018 IDLE, bit_en=1, FIFO non-empty: SHALL pop one sample, load shift register, drive ser_out=MSB, frame_sync=1, bit_cnt=DATA_W-1, go to SHIFT.
REQ-019 IDLE, bit_en=1, FIFO empty: SHALL hold ser_out=IDLE_BIT, frame_sync=0.
REQ-020 SHIFT, bit_en=1, bit_cnt>0: SHALL shift left, drive next bit, frame_sync=0, decrement bit_cnt.
REQ-021 SHIFT, bit_en=1, bit_cnt=0, FIFO non-empty: SHALL load next sample back-to-back with frame_sync=1, no idle gap.
REQ-022 SHIFT, bit_en=1, bit_cnt=0, FIFO empty: SHALL go to IDLE, ser_out=IDLE_BIT, pulse underrun for one clk.
REQ-023 SHALL leave ser_out, frame_sync, state and bit_cnt unchanged on cycles with bit_en=0.
REQ-024 A sample pushed in the same cycle as bit_en with empty FIFO SHALL NOT be popped that cycle; earliest emission is the next bit_en.
REQ-025 ser_out and frame_sync SHALL be registered; each bit holds for exactly one bit_en interval.
REQ-026 busy SHALL be 1 when state=SHIFT or FIFO non-empty, else 0.

Reset
REQ-027 rst_n=0 SHALL immediately force: FIFO empty, state IDLE, bit_cnt 0, ser_out=IDLE_BIT, frame_sync 0, underrun 0, busy 0, s_ready 1.
REQ-028 Reset mid-frame SHALL abort the frame; remaining bits and queued samples are discarded.
REQ-029 After rst_n deasserts, first frame SHALL start only on a bit_en following a new push.

Structure
REQ-030 Package fir_pkg SHALL hold DATA_W default, sample_t typedef (signed [DATA_W-1:0]) and the tx_state_t enum {IDLE, SHIFT}.
REQ-031 FIFO SHALL be a separate sub-module fir_sample_fifo (push/pop, full/empty, count); serializer FSM stays in fir_sample_tx.

Verification
REQ-032 Push 0xA5C3 into idle block, bit_en every 3 clk -> ser_out 1010010111000011 over 16 strobes, frame_sync on first only, then underrun pulse, ser_out=0.
REQ-033 Push 0x8001, 0x7FFE back-to-back, bit_en every clk -> 32 contiguous bits, frame_sync at bits 0 and 16, single underrun after bit 31.
REQ-034 Push 5 samples with bit_en=0 -> s_ready drops after 4th accepted; 5th held until first pop; all 5 emitted in order.
REQ-035 FIFO full, s_valid=1 and pop in same cycle -> no push that cycle; push accepted next cycle; count never exceeds 4.
REQ-036 rst_n low at bit 7 of 0x1234 with 2 samples queued -> ser_out=0, busy=0, s_ready=1 immediately; no further bits until new push.
REQ-037 push and bit_en in same cycle with empty FIFO -> frame_sync/MSB appear on next bit_en, not that cycle.
